// File: rtl/pipelined_datapath.sv
// pipelined_datapath: RD/EX/WB three-stage register-file, ALU and data-memory pipe.
// Optional DP_FWD_EN macro enables EX->RD forwarding of ALU results.
module pipelined_datapath #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              In_Valid,
  input  logic [DM_AW-1:0]  D_Addr,
  input  logic              D_Wr,
  input  logic              RF_s,
  input  logic              RF_W_en,
  input  logic [RF_AW-1:0]  RF_W_Addr,
  input  logic [RF_AW-1:0]  RF_Ra_Addr,
  input  logic [RF_AW-1:0]  RF_Rb_Addr,
  input  logic [2:0]        ALU_Sel,
  output logic [DATA_W-1:0] ALU_inA,
  output logic [DATA_W-1:0] ALU_inB,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Flag_Z,
  output logic              Flag_N,
  output logic              Flag_C
);

  localparam int RF_N = 2 ** RF_AW;
  localparam int DM_N = 2 ** DM_AW;

  typedef enum logic [2:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_PASS,
    ALU_XOR,  ALU_OR,  ALU_AND, ALU_INC
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [DM_AW-1:0] d_addr;
    logic             d_wr;
    logic             rf_s;
    logic             w_en;
    logic [RF_AW-1:0] w_addr;
    alu_op_e          sel;
  } ex_ctl_t;

  typedef struct packed {
    logic              valid;
    logic              rf_s;
    logic              w_en;
    logic [RF_AW-1:0]  w_addr;
    logic [DATA_W-1:0] alu;
    logic              c;
    logic [DATA_W-1:0] mem;
  } wb_t;

  ex_ctl_t           ex_q, ex_d;
  wb_t               wb_q, wb_d;
  logic [DATA_W-1:0] ina_q, ina_d;
  logic [DATA_W-1:0] inb_q, inb_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_c_q, flag_c_d;

  logic [DATA_W-1:0] rf_q [RF_N];
  logic [DATA_W-1:0] mem   [DM_N];

  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] out_data;
  logic              wb_wr;
  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign out_data = wb_q.rf_s ? wb_q.alu : wb_q.mem;
  assign wb_wr    = wb_q.valid && wb_q.w_en;

  // EX-stage ALU; the extra MSB carries carry-out or borrow
  always_comb begin
    wide = '0;
    unique case (ex_q.sel)
      ALU_ZERO: wide = '0;
      ALU_ADD:  wide = {1'b0, ina_q} + {1'b0, inb_q};
      ALU_SUB:  wide = {1'b0, ina_q} - {1'b0, inb_q};
      ALU_PASS: wide = {1'b0, ina_q};
      ALU_XOR:  wide = {1'b0, ina_q ^ inb_q};
      ALU_OR:   wide = {1'b0, ina_q | inb_q};
      ALU_AND:  wide = {1'b0, ina_q & inb_q};
      ALU_INC:  wide = {1'b0, ina_q} + (DATA_W+1)'(1);
    endcase
    alu_res = wide[DATA_W-1:0];
    alu_c   = wide[DATA_W];
  end

  // RD operand select: RF, then WB write-through, then EX forward
  always_comb begin
    rd_a = rf_q[RF_Ra_Addr];
    rd_b = rf_q[RF_Rb_Addr];
    if (wb_wr && wb_q.w_addr == RF_Ra_Addr) rd_a = out_data;
    if (wb_wr && wb_q.w_addr == RF_Rb_Addr) rd_b = out_data;
`ifdef DP_FWD_EN
    if (ex_q.valid && ex_q.w_en && ex_q.rf_s) begin
      if (ex_q.w_addr == RF_Ra_Addr) rd_a = alu_res;
      if (ex_q.w_addr == RF_Rb_Addr) rd_b = alu_res;
    end
`endif
  end

  // next-state for stage registers and flags
  always_comb begin
    ex_d       = ex_q;
    ex_d.valid = In_Valid;
    ina_d      = ina_q;
    inb_d      = inb_q;
    if (In_Valid) begin
      ex_d.d_addr = D_Addr;
      ex_d.d_wr   = D_Wr;
      ex_d.rf_s   = RF_s;
      ex_d.w_en   = RF_W_en;
      ex_d.w_addr = RF_W_Addr;
      ex_d.sel    = alu_op_e'(ALU_Sel);
      ina_d       = rd_a;
      inb_d       = rd_b;
    end
    wb_d.valid  = ex_q.valid;
    wb_d.rf_s   = ex_q.rf_s;
    wb_d.w_en   = ex_q.w_en;
    wb_d.w_addr = ex_q.w_addr;
    wb_d.alu    = alu_res;
    wb_d.c      = alu_c;
    wb_d.mem    = mem[ex_q.d_addr];
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_c_d = flag_c_q;
    if (wb_q.valid) begin
      flag_z_d = (wb_q.alu == '0);
      flag_n_d = wb_q.alu[DATA_W-1];
      flag_c_d = wb_q.c;
    end
  end

  // pipeline and flag registers
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ex_q     <= '0;
      ina_q    <= '0;
      inb_q    <= '0;
      wb_q     <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      ina_q    <= ina_d;
      inb_q    <= inb_d;
      wb_q     <= wb_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
    end
  end

  // register file: cleared on reset, written from WB
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < RF_N; i++) rf_q[i] <= '0;
    end else if (wb_wr) begin
      rf_q[wb_q.w_addr] <= out_data;
    end
  end

  // data memory: contents survive reset, writes suppressed during it
  always_ff @(posedge Clock) begin
    if (Reset_n && ex_q.valid && ex_q.d_wr) mem[ex_q.d_addr] <= ina_q;
  end

  assign ALU_inA   = ina_q;
  assign ALU_inB   = inb_q;
  assign Out_Valid = wb_q.valid;
  assign Out_Data  = out_data;
  assign Flag_Z    = flag_z_q;
  assign Flag_N    = flag_n_q;
  assign Flag_C    = flag_c_q;

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
Parametrised successor to the single-cycle register-file/ALU/data-memory datapath. Three-stage pipeline: operand read (RD), execute/memory (EX), write-back (WB). Accepts one operation per cycle from the control unit. Adds registered status flags, write-through register read, and optional EX->RD forwarding.

Parameters:
DATA_W, 16, datapath, register and memory word width in bits (>=4)
RF_AW, 4, register-file address width; RF depth = 2**RF_AW
DM_AW, 8, data-memory address width; depth = 2**DM_AW words

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  synchronous active-low reset
In_Valid  in  1  operation present this cycle
D_Addr  in  DM_AW  data-memory address
D_Wr  in  1  write operand A to memory at D_Addr
RF_s  in  1  write-back source: 1 = ALU result, 0 = memory read data
RF_W_en  in  1  write-back enable
RF_W_Addr  in  RF_AW  write-back register
RF_Ra_Addr  in  RF_AW  operand A register
RF_Rb_Addr  in  RF_AW  operand B register
ALU_Sel  in  3  0 zero, 1 A+B, 2 A-B, 3 pass A, 4 A^B, 5 A|B, 6 A&B, 7 A+1
ALU_inA  out  DATA_W  EX-stage operand A (registered)
ALU_inB  out  DATA_W  EX-stage operand B (registered)
Out_Valid  out  1  WB stage holds a valid op
Out_Data  out  DATA_W  write-back value of the WB op
Flag_Z, Flag_N, Flag_C  out  1 each  zero, sign (MSB), carry/borrow of the last WB ALU result

Behaviour:
- Issue cycle n (RD): when In_Valid=1, control fields and RF read data are captured into EX registers at the end of n. RF reads are combinational. If the WB write address equals the read address in the same cycle, the read returns the WB value (write-through).
- EX (cycle n+1): ALU operates on ALU_inA/ALU_inB. Memory is synchronous. If D_Wr, mem[D_Addr]<=ALU_inA at the end of n+1. The read at D_Addr returns the pre-write contents (read-during-write old data). ALU result and memory q are registered at the end of n+1.
- WB (cycle n+2): Out_Valid=1. Out_Data = RF_s ? ALU result : memory data. If RF_W_en, RF[RF_W_Addr]<=Out_Data at the end of n+2. Flags update at the end of n+2 and hold otherwise.
- Latency: 2 cycles issue->Out_Valid. Throughput: 1 op/cycle with no stalls.
- Bubbles: In_Valid=0 propagates as an invalid stage. An invalid EX stage performs no memory write. An invalid WB stage performs no RF write and leaves the flags unchanged.
- Arithmetic: all results are mod 2**DATA_W.
  - Add/inc: C = carry-out.
  - Sub: C = 1 when A<B unsigned (borrow).
  - Logic/pass/zero: C=0.
  - Z = result==0. N = result[DATA_W-1].
- Hazards (no forwarding): an op that depends on a write-back must issue >=2 cycles after the producer (one independent op or bubble between).
- Register 0 is an ordinary register. Address wrap is not applicable; all addresses are full range.
- Reset (Reset_n=0 at an edge):
  - All stage valids cleared; in-flight ops discarded, with no RF or memory write even if in EX/WB that cycle.
  - All RF entries <= 0.
  - ALU_inA, ALU_inB, Out_Data, Out_Valid and flags <= 0.
  - Memory contents are not cleared.
- Op issued in the cycle Reset_n returns high is accepted normally.

Optional Feature:
DP_FWD_EN
- Defined: EX->RD forwarding. If the EX op has RF_W_en=1, RF_s=1 and RF_W_Addr matches Ra/Rb of the issuing op, its combinational ALU result is captured as the operand instead of the RF value. Back-to-back dependent ALU ops then run at full rate.
  - Memory-sourced results (RF_s=0) are not forwarded; load-use still needs a 1-op gap.
  - Forwarding has priority over write-through when both match.
- Undefined: no forwarding path; only WB write-through exists.

Test Plan:
1. Reset, then op Ra=0,Rb=0,Sel=7,W_en=1,W=1,RF_s=1 -> Out_Valid at issue+2, Out_Data=1, R1=1, Z=0,N=0,C=0.
2. R1=1. Issue A: R2=R1+R1. One bubble. Issue B: R3=R2+R1 -> B's Out_Data=3 without DP_FWD_EN. Issue the same pair back-to-back -> 3 with DP_FWD_EN, 1 without.
3. R2=2. Op Ra=2,D_Addr=6,D_Wr=1. Then op D_Addr=6,RF_s=0,W_en=1,W=4 -> R4=2. Same-cycle write and read of address 6 returns old contents.
4. R1=1, R2=2. R5=R1-R2 (Sel=2) -> Out_Data=0xFFFF (DATA_W=16), N=1, C=1, Z=0. Then R6=R5+R1 -> 0x0000, Z=1, C=1.
5. Sel=0 op -> Out_Data=0, Z=1, C=0. A bubble (In_Valid=0) follows -> flags and RF unchanged, Out_Valid=0.
6. Reset_n low while a D_Wr op is in EX and a W_en op is in WB -> memory location and RF unchanged, all RF read 0, outputs 0 the next cycle.
